// File: rtl/spi_xip_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_xip_pkg : shared types and constants for the SPI XIP sequencer    |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
package spi_xip_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2,
    GAP   = 2'd3
  } state_e;

  localparam logic [7:0] SPI_READ_CMD   = 8'h03;
  localparam int         SPI_FRAME_BITS = 64;
  localparam int         SPI_DATA_BITS  = 32;

  // Bytes arrive MSB-first into rx; the first byte must land in data[7:0].
  function automatic logic [31:0] le_word(input logic [31:0] rx);
    return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_xip_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_xip_shifter : mode-0 serializer for one 64-bit READ frame         |
// | Revision        : 1.0                                                 |
// +----------------------------------------------------------------------+
module spi_xip_shifter
  import spi_xip_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [23:0] addr_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        sclk_o,
  output logic        mosi_o,
  input  logic        miso_i,
  output logic [31:0] rx_o
);

  localparam logic [7:0] C_DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [5:0] C_BIT_LAST = 6'(SPI_FRAME_BITS - 1);
  localparam logic [5:0] C_BIT_RX   = 6'(SPI_FRAME_BITS - SPI_DATA_BITS);

  logic [7:0]  div_q;
  logic [5:0]  bit_q;
  logic [31:0] tx_q;
  logic [31:0] rx_q;
  logic        sclk_q;
  logic        mosi_q;
  logic        busy_q;
  logic        w_edge;

  assign w_edge = busy_q && (div_q == C_DIV_LAST);
  assign done_o = w_edge && sclk_q && (bit_q == C_BIT_LAST);
  assign busy_o = busy_q;
  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;
  assign rx_o   = rx_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q  <= '0;
      bit_q  <= '0;
      tx_q   <= '0;
      rx_q   <= '0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      // Bit 0 goes out with the first low phase, so preload it now.
      busy_q <= 1'b1;
      div_q  <= '0;
      bit_q  <= '0;
      sclk_q <= 1'b0;
      mosi_q <= SPI_READ_CMD[7];
      tx_q   <= {SPI_READ_CMD[6:0], addr_i, 1'b0};
    end else if (busy_q) begin
      div_q <= w_edge ? 8'd0 : div_q + 8'd1;
      if (w_edge) begin
        sclk_q <= !sclk_q;
        if (!sclk_q) begin
          if (bit_q >= C_BIT_RX) begin
            rx_q <= {rx_q[30:0], miso_i};
          end
        end else if (bit_q == C_BIT_LAST) begin
          busy_q <= 1'b0;
        end else begin
          // Zeros shifted in make mosi idle low through the data bits.
          bit_q  <= bit_q + 6'd1;
          mosi_q <= tx_q[31];
          tx_q   <= {tx_q[30:0], 1'b0};
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_xip_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_xip_sequencer : two-port round-robin SPI NOR word reader          |
// | Revision          : 1.0                                               |
// +----------------------------------------------------------------------+
module spi_xip_sequencer
  import spi_xip_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CS_HIGH = 4
) (
  input  logic        io_clock,
  input  logic        io_rst_n,
  input  logic        io_req0_valid,
  output logic        io_req0_ready,
  input  logic [23:0] io_req0_addr,
  output logic        io_rsp0_valid,
  output logic [31:0] io_rsp0_data,
  input  logic        io_req1_valid,
  output logic        io_req1_ready,
  input  logic [23:0] io_req1_addr,
  output logic        io_rsp1_valid,
  output logic [31:0] io_rsp1_data,
  output logic        io_spiXip_ss,
  output logic        io_spiXip_sclk,
  output logic        io_spiXip_mosi,
  input  logic        io_spiXip_miso
);

  localparam logic [7:0] C_CS_HIGH = 8'(CS_HIGH);

  state_e      state_q, state_d;
  logic        prio_q, prio_d;
  logic        gnt_q, gnt_d;
  logic [7:0]  gap_q, gap_d;
  logic        ss_q, ss_d;
  logic        rsp0_valid_q, rsp0_valid_d;
  logic        rsp1_valid_q, rsp1_valid_d;
  logic [31:0] rsp0_data_q, rsp0_data_d;
  logic [31:0] rsp1_data_q, rsp1_data_d;

  logic        w_pick;
  logic        w_grant;
  logic [23:0] w_addr;
  logic        w_busy;
  logic        w_done;
  logic [31:0] w_rx;

  // prio_q names the port that wins a tie; it flips to the loser on each grant.
  assign w_pick  = (io_req0_valid && io_req1_valid) ? prio_q : io_req1_valid;
  assign w_grant = (state_q == IDLE) && !w_busy && (io_req0_valid || io_req1_valid);
  assign w_addr  = w_pick ? io_req1_addr : io_req0_addr;

  assign io_req0_ready  = w_grant && !w_pick;
  assign io_req1_ready  = w_grant && w_pick;
  assign io_rsp0_valid  = rsp0_valid_q;
  assign io_rsp1_valid  = rsp1_valid_q;
  assign io_rsp0_data   = rsp0_data_q;
  assign io_rsp1_data   = rsp1_data_q;
  assign io_spiXip_ss   = ss_q;

  spi_xip_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk_i   (io_clock),
    .rst_ni  (io_rst_n),
    .start_i (w_grant),
    .addr_i  (w_addr),
    .busy_o  (w_busy),
    .done_o  (w_done),
    .sclk_o  (io_spiXip_sclk),
    .mosi_o  (io_spiXip_mosi),
    .miso_i  (io_spiXip_miso),
    .rx_o    (w_rx)
  );

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    gnt_d        = gnt_q;
    gap_d        = gap_q;
    ss_d         = ss_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rsp0_data_d  = rsp0_data_q;
    rsp1_data_d  = rsp1_data_q;
    case (state_q)
      IDLE: begin
        if (w_grant) begin
          state_d = SHIFT;
          gnt_d   = w_pick;
          prio_d  = !w_pick;
          ss_d    = 1'b0;
        end
      end
      SHIFT: begin
        if (w_done) begin
          state_d = DONE;
          ss_d    = 1'b1;
          if (gnt_q) begin
            rsp1_valid_d = 1'b1;
            rsp1_data_d  = le_word(w_rx);
          end else begin
            rsp0_valid_d = 1'b1;
            rsp0_data_d  = le_word(w_rx);
          end
        end
      end
      DONE: begin
        // DONE is the first of the CS_HIGH deselect cycles.
        gap_d   = 8'd2;
        state_d = (C_CS_HIGH == 8'd1) ? IDLE : GAP;
      end
      GAP: begin
        gap_d = gap_q + 8'd1;
        if (gap_q == C_CS_HIGH) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge io_clock or negedge io_rst_n) begin
    if (!io_rst_n) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      gnt_q        <= 1'b0;
      gap_q        <= '0;
      ss_q         <= 1'b1;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      gnt_q        <= gnt_d;
      gap_q        <= gap_d;
      ss_q         <= ss_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_xip_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_spi_xip_sequencer : bench with SPI flash models and a scoreboard   |
// | Revision             : 1.0                                            |
// +----------------------------------------------------------------------+
module tb_spi_xip_sequencer;

  localparam int LAT_A = 1 + 128 * 2;
  localparam int CS_A  = 4;

  typedef struct {
    logic        p;
    logic [23:0] a;
    int          t;
  } exp_t;

  typedef struct {
    logic        p;
    logic [23:0] a;
    logic [31:0] d;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic [1:0]  a_valid = 2'b00;
  logic [23:0] a_addr [2] = '{24'h0, 24'h0};
  wire  [1:0]  a_ready;
  wire  [1:0]  a_rspv;
  wire  [31:0] a_data [2];

  logic        b_valid0 = 1'b0;
  logic        b_valid1 = 1'b0;
  logic [23:0] b_addr0 = 24'h0;
  logic [23:0] b_addr1 = 24'h0;
  wire         b_ready0, b_ready1, b_rsp0, b_rsp1;
  wire  [31:0] b_data0, b_data1;

  wire  [1:0]  ss_w, sclk_w, mosi_w, miso_w;

  exp_t        sb[$];
  int          grants[$];
  int          gcyc[$];
  int          n_rsp = 0;
  bit          cont_mode = 1'b0;
  bit          have_last = 1'b0;
  int          last_rsp_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h000100: return 8'h11;
      24'h000101: return 8'h22;
      24'h000102: return 8'h33;
      24'h000103: return 8'h44;
      default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input logic [23:0] a);
    return {flash_byte(a + 24'd3), flash_byte(a + 24'd2), flash_byte(a + 24'd1), flash_byte(a)};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out / unexpected event (cycle %0d)", name, cyc);
  endtask

  spi_xip_sequencer u_dut_a (
    .io_clock       (clk),
    .io_rst_n       (rst_n),
    .io_req0_valid  (a_valid[0]),
    .io_req0_ready  (a_ready[0]),
    .io_req0_addr   (a_addr[0]),
    .io_rsp0_valid  (a_rspv[0]),
    .io_rsp0_data   (a_data[0]),
    .io_req1_valid  (a_valid[1]),
    .io_req1_ready  (a_ready[1]),
    .io_req1_addr   (a_addr[1]),
    .io_rsp1_valid  (a_rspv[1]),
    .io_rsp1_data   (a_data[1]),
    .io_spiXip_ss   (ss_w[0]),
    .io_spiXip_sclk (sclk_w[0]),
    .io_spiXip_mosi (mosi_w[0]),
    .io_spiXip_miso (miso_w[0])
  );

  spi_xip_sequencer #(
    .CLK_DIV (1),
    .CS_HIGH (1)
  ) u_dut_b (
    .io_clock       (clk),
    .io_rst_n       (rst_n),
    .io_req0_valid  (b_valid0),
    .io_req0_ready  (b_ready0),
    .io_req0_addr   (b_addr0),
    .io_rsp0_valid  (b_rsp0),
    .io_rsp0_data   (b_data0),
    .io_req1_valid  (b_valid1),
    .io_req1_ready  (b_ready1),
    .io_req1_addr   (b_addr1),
    .io_rsp1_valid  (b_rsp1),
    .io_rsp1_data   (b_data1),
    .io_spiXip_ss   (ss_w[1]),
    .io_spiXip_sclk (sclk_w[1]),
    .io_spiXip_mosi (mosi_w[1]),
    .io_spiXip_miso (miso_w[1])
  );

  // Mode-0 READ flash: captures cmd+addr on rising sclk, shifts data on falling sclk.
  for (genvar gi = 0; gi < 2; gi++) begin : g_flash
    int          nb = 0;
    logic        ps = 1'b0;
    logic        mo = 1'b0;
    logic [31:0] sh = '0;
    logic [7:0]  cap_cmd = '0;
    logic [23:0] cap_addr = '0;
    assign miso_w[gi] = mo;

    always @(ss_w[gi] or sclk_w[gi]) begin
      if (ss_w[gi]) begin
        nb = 0;
        mo = 1'b0;
      end else if (sclk_w[gi] && !ps) begin
        if (nb < 32) sh = {sh[30:0], mosi_w[gi]};
        nb++;
        if (nb == 32) begin
          cap_cmd  = sh[31:24];
          cap_addr = sh[23:0];
        end
      end else if (!sclk_w[gi] && ps && nb >= 32 && nb < 64) begin
        automatic int          j = nb - 32;
        automatic logic [7:0]  b = flash_byte(cap_addr + 24'(j / 8));
        mo = b[7 - (j % 8)];
      end
      ps = sclk_w[gi];
    end
  end

  // Scoreboard for instance A: expectations pushed at grant, popped at response.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      have_last <= 1'b0;
    end else begin
      if (!cont_mode) have_last <= 1'b0;
      for (int p = 0; p < 2; p++) begin
        if (a_valid[p] && a_ready[p]) begin
          if (cont_mode && have_last) chk("gap_cycles", 32'(cyc - last_rsp_cyc), 32'(CS_A));
          sb.push_back('{p[0], a_addr[p], cyc});
          grants.push_back(p);
          gcyc.push_back(cyc);
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (a_rspv[p]) begin
          if (sb.size() == 0) begin
            fail($sformatf("unexpected_rsp%0d", p));
          end else begin
            automatic exp_t e = sb.pop_front();
            chk("rsp_port", 32'(p), 32'(e.p));
            chk("rsp_data", a_data[p], exp_word(e.a));
            chk("rsp_latency", 32'(cyc - e.t), 32'(LAT_A));
            chk("mosi_cmd", 32'(g_flash[0].cap_cmd), 32'h03);
            chk("mosi_addr", 32'(g_flash[0].cap_addr), 32'(e.a));
            chk("ss_in_done", 32'(ss_w[0]), 32'd1);
          end
          n_rsp++;
          last_rsp_cyc <= cyc;
          have_last    <= 1'b1;
        end
      end
    end
  end

  task automatic do_req(input int p, input logic [23:0] a, output int t);
    bit ok = 1'b0;
    t = 0;
    @(posedge clk); #1;
    a_valid[p] = 1'b1;
    a_addr[p]  = a;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (a_ready[p]) begin ok = 1'b1; t = cyc; break; end
    end
    if (!ok) fail("req_ready_timeout");
    @(posedge clk); #1;
    a_valid[p] = 1'b0;
  endtask

  task automatic wait_all();
    bit ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (sb.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) fail("rsp_timeout");
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  vec_t        vecs [4];
  logic [31:0] held [2];
  int          t, t0, ng, nr;
  logic [1:0]  got;
  int          rdy_b[$];
  int          rsp_b[$];
  logic        s1, s2, s3;

  initial begin
    vecs[0] = '{1'b0, 24'h000100, 32'h44332211};
    vecs[1] = '{1'b1, 24'h000200, exp_word(24'h000200)};
    vecs[2] = '{1'b1, 24'hFFFFFE, {flash_byte(24'h000001), flash_byte(24'h000000),
                                   flash_byte(24'hFFFFFF), flash_byte(24'hFFFFFE)}};
    vecs[3] = '{1'b0, 24'hABCDEF, exp_word(24'hABCDEF)};
    held[0] = '0;
    held[1] = '0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ss", 32'(ss_w[0]), 32'd1);
    chk("rst_sclk", 32'(sclk_w[0]), 32'd0);
    chk("rst_mosi", 32'(mosi_w[0]), 32'd0);
    chk("rst_ready", 32'(a_ready), 32'd0);
    chk("rst_rspv", 32'(a_rspv), 32'd0);
    chk("rst_data0", a_data[0], 32'd0);
    chk("rst_data1", a_data[1], 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven single reads, including the wrapping address
    foreach (vecs[i]) begin
      do_req(int'(vecs[i].p), vecs[i].a, t);
      wait_all();
      held[vecs[i].p] = vecs[i].d;
      chk($sformatf("vec%0d_data", i), a_data[vecs[i].p], vecs[i].d);
      chk($sformatf("vec%0d_hold", i), a_data[!vecs[i].p], held[!vecs[i].p]);
    end

    // Both valid together after reset: port 0 first, port 1 at T0+261
    pulse_reset();
    ng = grants.size();
    @(posedge clk); #1;
    a_addr[0] = 24'h000000;
    a_addr[1] = 24'h000004;
    a_valid   = 2'b11;
    for (int c = 0; c < 800 && a_valid != 2'b00; c++) begin
      @(negedge clk);
      got = a_ready & a_valid;
      if (got != 2'b00) begin
        @(posedge clk); #1;
        a_valid = a_valid & ~got;
      end
    end
    if (a_valid != 2'b00) begin fail("both_grant_timeout"); a_valid = 2'b00; end
    wait_all();
    if (grants.size() >= ng + 2) begin
      chk("both_first", 32'(grants[ng]), 32'd0);
      chk("both_second", 32'(grants[ng + 1]), 32'd1);
      chk("both_spacing", 32'(gcyc[ng + 1] - gcyc[ng]), 32'(LAT_A + CS_A));
    end else fail("both_grants");

    // Continuous requests on both ports: alternate grants, CS_HIGH gap
    ng = grants.size();
    cont_mode = 1'b1;
    @(posedge clk); #1;
    a_addr[0] = 24'h000010;
    a_addr[1] = 24'h000020;
    a_valid   = 2'b11;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (grants.size() >= ng + 4) break;
    end
    @(posedge clk); #1;
    a_valid = 2'b00;
    wait_all();
    cont_mode = 1'b0;
    if (grants.size() >= ng + 4) begin
      for (int i = 0; i < 4; i++) chk("alt_grant", 32'(grants[ng + i]), 32'(i % 2));
    end else fail("cont_grants");

    // Reset at bit 40 of a port 1 read
    do_req(1, 24'h000300, t);
    while (cyc < t + 162) @(negedge clk);
    chk("pre_rst_ss", 32'(ss_w[0]), 32'd0);
    nr = n_rsp;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_ss", 32'(ss_w[0]), 32'd1);
    chk("midrst_sclk", 32'(sclk_w[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("midrst_no_rsp", 32'(n_rsp - nr), 32'd0);
    chk("midrst_data1", a_data[1], 32'd0);
    do_req(1, 24'h000400, t);
    wait_all();
    chk("post_rst_data1", a_data[1], exp_word(24'h000400));

    // CLK_DIV=1, CS_HIGH=1 instance: back-to-back port 0 reads
    @(posedge clk); #1;
    b_addr0  = 24'h000040;
    b_valid0 = 1'b1;
    s1 = 1'bx; s2 = 1'bx; s3 = 1'bx;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (rdy_b.size() == 1 && cyc == rdy_b[0] + 1) s1 = sclk_w[1];
      if (rdy_b.size() == 1 && cyc == rdy_b[0] + 2) s2 = sclk_w[1];
      if (rdy_b.size() == 1 && cyc == rdy_b[0] + 3) s3 = sclk_w[1];
      if (b_ready0) rdy_b.push_back(cyc);
      if (b_rsp0) begin
        rsp_b.push_back(cyc);
        chk("fast_data", b_data0, exp_word(24'h000040));
        chk("fast_addr", 32'(g_flash[1].cap_addr), 32'h000040);
      end
      if (rdy_b.size() == 2) break;
    end
    @(posedge clk); #1;
    b_valid0 = 1'b0;
    if (rdy_b.size() == 2 && rsp_b.size() >= 1) begin
      chk("fast_rsp_lat", 32'(rsp_b[0] - rdy_b[0]), 32'd129);
      chk("fast_next_rdy", 32'(rdy_b[1] - rdy_b[0]), 32'd130);
      chk("fast_sclk1", 32'(s1), 32'd0);
      chk("fast_sclk2", 32'(s2), 32'd1);
      chk("fast_sclk3", 32'(s3), 32'd0);
    end else fail("fast_timeout");
    chk("fast_no_rsp1", 32'(b_rsp1), 32'd0);
    repeat (200) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
